// File: rtl/rtc_lectura_bus.sv
// rtc_lectura_bus: read engine for the RTC multiplexed address/data port.
// A start pulse latches an RTC register address, drives the address phase
// (A/D low, CS/WR strobes), turns the bus around, runs the data phase
// (A/D high, CS/RD strobes) and routes the returned byte into the matching
// time/date/timer holding register.
// Bus outputs are registered copies of a decode of the *next* state, so
// every strobe changes on the same edge as the state register and never
// glitches.
module rtc_lectura_bus #(
  parameter int unsigned PULSO = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [7:0] dir,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic       ocupado,
  output logic       listo,
  output logic [7:0] dato_leido,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] seg_tim,
  output logic [7:0] min_tim,
  output logic [7:0] hora_tim
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIR_ESC = 3'd1,
    DIR_FIN = 3'd2,
    ESPERA  = 3'd3,
    LEER    = 3'd4,
    FIN     = 3'd5
  } state_t;

  // Last value of the phase counter inside a PULSO-long state.
  localparam logic [7:0] CNT_LAST = 8'(PULSO - 1);

  // One-hot index of each holding register in the decode vector.
  localparam int unsigned H_SEG      = 0;
  localparam int unsigned H_MIN      = 1;
  localparam int unsigned H_HORA     = 2;
  localparam int unsigned H_DIA      = 3;
  localparam int unsigned H_MES      = 4;
  localparam int unsigned H_ANIO     = 5;
  localparam int unsigned H_SEG_TIM  = 6;
  localparam int unsigned H_MIN_TIM  = 7;
  localparam int unsigned H_HORA_TIM = 8;

  // Map an RTC register address to a one-hot holding-register select;
  // unmapped addresses select nothing.
  function automatic logic [8:0] decode_dir(input logic [7:0] a);
    logic [8:0] sel;
    sel = 9'b0;
    case (a)
      8'h21:   sel[H_SEG]      = 1'b1;
      8'h22:   sel[H_MIN]      = 1'b1;
      8'h23:   sel[H_HORA]     = 1'b1;
      8'h24:   sel[H_DIA]      = 1'b1;
      8'h25:   sel[H_MES]      = 1'b1;
      8'h26:   sel[H_ANIO]     = 1'b1;
      8'h41:   sel[H_SEG_TIM]  = 1'b1;
      8'h42:   sel[H_MIN_TIM]  = 1'b1;
      8'h43:   sel[H_HORA_TIM] = 1'b1;
      default: sel = 9'b0;
    endcase
    return sel;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  cnt_r;
  logic [7:0]  addr_r;
  logic [7:0]  addr_s;
  logic        fase_fin_s;
  logic        captura_s;
  logic [8:0]  sel_s;

  logic [7:0]  ad_out_s;
  logic        ad_oe_s;
  logic        cs_n_s;
  logic        rd_n_s;
  logic        wr_n_s;
  logic        a_d_s;
  logic        ocupado_s;
  logic        listo_s;

  assign fase_fin_s = (cnt_r == CNT_LAST);
  // The byte is taken on the edge that closes the last read cycle.
  assign captura_s  = (state_r == LEER) && fase_fin_s;
  assign sel_s      = decode_dir(addr_r);
  // Address as it will be after this edge: the new one on acceptance.
  assign addr_s     = (state_r == IDLE) ? dir : addr_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: PULSO-long phases leave on the last counter value.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (inicio) begin
          state_s = DIR_ESC;
        end else begin
          state_s = IDLE;
        end
      end
      DIR_ESC: begin
        if (fase_fin_s) begin
          state_s = DIR_FIN;
        end else begin
          state_s = DIR_ESC;
        end
      end
      DIR_FIN: state_s = ESPERA;
      ESPERA: begin
        if (fase_fin_s) begin
          state_s = LEER;
        end else begin
          state_s = ESPERA;
        end
      end
      LEER: begin
        if (fase_fin_s) begin
          state_s = FIN;
        end else begin
          state_s = LEER;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Phase counter: cleared on every state change and held at zero in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= 8'd0;
    end else if ((state_s != state_r) || (state_r == IDLE)) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  // Address latch: only loaded when a start request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r <= 8'h00;
    end else if ((state_r == IDLE) && inicio) begin
      addr_r <= dir;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Output decode of the next state, registered below.
  always_comb begin
    ad_out_s  = 8'h00;
    ad_oe_s   = 1'b0;
    cs_n_s    = 1'b1;
    rd_n_s    = 1'b1;
    wr_n_s    = 1'b1;
    a_d_s     = 1'b1;
    ocupado_s = 1'b1;
    listo_s   = 1'b0;
    case (state_s)
      IDLE: begin
        ocupado_s = 1'b0;
      end
      DIR_ESC: begin
        a_d_s    = 1'b0;
        cs_n_s   = 1'b0;
        wr_n_s   = 1'b0;
        ad_oe_s  = 1'b1;
        ad_out_s = addr_s;
      end
      DIR_FIN: begin
        // Address hold time after the WR rising edge.
        a_d_s    = 1'b0;
        ad_oe_s  = 1'b1;
        ad_out_s = addr_s;
      end
      ESPERA: begin
        // Turnaround: nobody drives the bus.
        a_d_s = 1'b1;
      end
      LEER: begin
        cs_n_s = 1'b0;
        rd_n_s = 1'b0;
      end
      FIN: begin
        listo_s = 1'b1;
      end
      default: begin
        ocupado_s = 1'b0;
      end
    endcase
  end

  // Registered bus and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ad_out  <= 8'h00;
      ad_oe   <= 1'b0;
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      a_d     <= 1'b1;
      ocupado <= 1'b0;
      listo   <= 1'b0;
    end else begin
      ad_out  <= ad_out_s;
      ad_oe   <= ad_oe_s;
      cs_n    <= cs_n_s;
      rd_n    <= rd_n_s;
      wr_n    <= wr_n_s;
      a_d     <= a_d_s;
      ocupado <= ocupado_s;
      listo   <= listo_s;
    end
  end

  // Captured byte and holding registers, written only on entry to FIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dato_leido <= 8'h00;
      seg        <= 8'h00;
      min        <= 8'h00;
      hora       <= 8'h00;
      dia        <= 8'h00;
      mes        <= 8'h00;
      anio       <= 8'h00;
      seg_tim    <= 8'h00;
      min_tim    <= 8'h00;
      hora_tim   <= 8'h00;
    end else if (captura_s) begin
      dato_leido <= ad_in;
      seg        <= sel_s[H_SEG]      ? ad_in : seg;
      min        <= sel_s[H_MIN]      ? ad_in : min;
      hora       <= sel_s[H_HORA]     ? ad_in : hora;
      dia        <= sel_s[H_DIA]      ? ad_in : dia;
      mes        <= sel_s[H_MES]      ? ad_in : mes;
      anio       <= sel_s[H_ANIO]     ? ad_in : anio;
      seg_tim    <= sel_s[H_SEG_TIM]  ? ad_in : seg_tim;
      min_tim    <= sel_s[H_MIN_TIM]  ? ad_in : min_tim;
      hora_tim   <= sel_s[H_HORA_TIM] ? ad_in : hora_tim;
    end else begin
      dato_leido <= dato_leido;
      seg        <= seg;
      min        <= min;
      hora       <= hora;
      dia        <= dia;
      mes        <= mes;
      anio       <= anio;
      seg_tim    <= seg_tim;
      min_tim    <= min_tim;
      hora_tim   <= hora_tim;
    end
  end

endmodule
